ascii_number_parser: RTL and testbench
======================================

ASCII_NUMBER_PARSER -- requirements
Module: ascii_number_parser

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of the result.
REQ-002 The block SHALL have parameter MAX_DIGITS, default 10, giving the maximum number of digits accepted per number (1..15).
REQ-003 The block SHALL have parameter ACCEPT_SIGN, default 1: 1 = two's-complement result with optional leading '-'; 0 = unsigned result, '-' is illegal.
REQ-004 The ports SHALL be as follows; the block has one clock, and reset is asynchronous and active-low:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort of the current number
- rx_data  in  8  ASCII character
- rx_valid  in  1  one-cycle strobe qualifying rx_data
- value  out  DATA_WIDTH  last completed number
- value_valid  out  1  one-cycle pulse, value updated
- digit_count  out  4  digits in the number being parsed or just completed
- error  out  1  one-cycle pulse, number rejected
- overflow  out  1  sticky, set with an overflow error, cleared by clear or the next accepted digit in IDLE
- busy  out  1  high when state != IDLE

Function
REQ-005 The block SHALL treat '0'..'9' (0x30..0x39) as digits, i.e. rx_data-0x30.
REQ-006 The block SHALL treat CR 0x0D, LF 0x0A, space 0x20 and ',' 0x2C as terminators.
REQ-007 The block SHALL treat every other character, including '-' when ACCEPT_SIGN=0, as illegal.
REQ-008 The block SHALL use a state machine with states IDLE, SIGN, ACCUM and DISCARD, and SHALL consume characters only on cycles with rx_valid=1.
REQ-009 In IDLE, the block SHALL:
- ignore terminators;
- on '-' (ACCEPT_SIGN=1), set neg, clear acc and go to SIGN;
- on a digit, set acc=digit, digit_count=1, neg=0, clear overflow and go to ACCUM;
- on an illegal character, pulse error and go to DISCARD.
REQ-010 In SIGN, the block SHALL:
- on a digit, set acc=digit, digit_count=1 and go to ACCUM;
- on a terminator, pulse error and go to IDLE ("-" alone is rejected);
- on anything else, pulse error and go to DISCARD.
REQ-011 In ACCUM on a digit, the block SHALL set acc=acc*10+digit and digit_count+1.
REQ-012 In ACCUM, if digit_count==MAX_DIGITS or the new acc would exceed LIMIT, the block SHALL instead set overflow, pulse error and go to DISCARD.
REQ-013 LIMIT SHALL be 2^DATA_WIDTH-1 when ACCEPT_SIGN=0; 2^(DATA_WIDTH-1)-1 when ACCEPT_SIGN=1 and neg=0; and 2^(DATA_WIDTH-1) when neg=1.
REQ-014 The block SHALL hold acc in an internal register of at least DATA_WIDTH+4 bits so that the comparison against LIMIT is exact.
REQ-015 In ACCUM on a terminator, the block SHALL register value = neg ? -acc : acc (truncated to DATA_WIDTH), pulse value_valid on the following cycle, hold digit_count, and go to IDLE.
REQ-016 In ACCUM on an illegal character, the block SHALL pulse error and go to DISCARD.
REQ-017 In DISCARD, the block SHALL drop all characters until a terminator, then return to IDLE without a further error pulse.
REQ-018 Both error and value_valid SHALL assert exactly one cycle after the rx_valid cycle that caused them, and never together.
REQ-019 value SHALL hold its last completed result until the next completed number; error SHALL NOT modify value.
REQ-020 When clear=1, the block SHALL go to IDLE and zero acc, neg, digit_count and overflow; the rx_valid character in the same cycle SHALL be dropped.
REQ-021 Characters arriving on back-to-back cycles SHALL all be processed, with no stall.

Reset
REQ-022 On reset low, regardless of clk, the block SHALL set state=IDLE and value, value_valid, digit_count, error, overflow, busy, acc and neg all to 0.
REQ-023 After reset deasserts mid-number, the block SHALL resume parsing only from the next character, with no output pulse.

Verification
REQ-024 "123\r" with defaults -> value=123, value_valid high for 1 cycle, digit_count=3, error never high.
REQ-025 "-45\n" with ACCEPT_SIGN=1 -> value=32'hFFFFFFD3; "-2147483648 " -> value=32'h80000000; "2147483648 " -> error pulse, overflow=1, value unchanged.
REQ-026 "4294967296\r" with ACCEPT_SIGN=0 -> error and overflow, no value_valid; "4294967295\r" -> value=32'hFFFFFFFF.
REQ-027 "12a4\r7\r" -> one error pulse at 'a', '4' ignored, then value=7 with value_valid; "-\r" -> error pulse, return to IDLE.
REQ-028 "98" then reset low for 2 cycles, then "5\r" -> value=5, digit_count=1; clear asserted together with '6' mid-number "3" then "1\r" -> value=1.
REQ-029 "1,2,3," sent on back-to-back cycles -> three value_valid pulses with values 1, 2, 3.

Source files
------------

// File: rtl/ascii_number_parser_if.sv
// Character stream in, parsed number and status out, for ascii_number_parser.
interface ascii_number_parser_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  clear;
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] value;
    logic                  value_valid;
    logic [3:0]            digit_count;
    logic                  error;
    logic                  overflow;
    logic                  busy;

    // Character source side (drives characters and clear)
    modport master (
        output clear, rx_data, rx_valid,
        input  value, value_valid, digit_count, error, overflow, busy
    );

    // Parser side
    modport slave (
        input  clear, rx_data, rx_valid,
        output value, value_valid, digit_count, error, overflow, busy
    );
endinterface

// File: rtl/ascii_number_parser.sv
// Streaming ASCII decimal parser: accumulates digits up to a terminator,
// optionally with a leading '-', rejecting illegal characters and overflow.
module ascii_number_parser #(
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_DIGITS  = 10,
    parameter int ACCEPT_SIGN = 1
) (
    input logic                  clk,
    input logic                  reset,
    ascii_number_parser_if.slave bus
);
    // Four spare bits keep acc*10+9 exact for any acc up to the limit.
    localparam int AW = DATA_WIDTH + 4;
    localparam logic [AW-1:0] LIM_U = {4'b0, {DATA_WIDTH{1'b1}}};
    localparam logic [AW-1:0] LIM_P = {5'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [AW-1:0] LIM_N = {4'b0, 1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [3:0]    MAXD  = 4'(MAX_DIGITS);

    typedef enum logic [1:0] {IDLE, SIGN, ACCUM, DISCARD} state_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic is_term(input logic [7:0] c);
        return (c == 8'h0D) || (c == 8'h0A) || (c == 8'h20) || (c == 8'h2C);
    endfunction

    // Largest magnitude representable for the current sign.
    function automatic logic [AW-1:0] limit_for(input logic neg);
        if (ACCEPT_SIGN == 0) return LIM_U;
        return neg ? LIM_N : LIM_P;
    endfunction

    // Two's-complement negation of the magnitude, truncated to the result width.
    function automatic logic [DATA_WIDTH-1:0] apply_sign(input logic [DATA_WIDTH-1:0] mag,
                                                         input logic neg);
        return neg ? (~mag + 1'b1) : mag;
    endfunction

    state_t                state_q, state_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic                  neg_q, neg_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] value_q, value_d;
    logic                  vv_q, vv_d;
    logic                  err_q, err_d;
    logic                  ovf_q, ovf_d;

    logic                  c_digit, c_term, c_minus;
    logic [3:0]            digit_val;
    logic [AW-1:0]         acc_x10;

    assign c_digit   = is_digit(bus.rx_data);
    assign c_term    = is_term(bus.rx_data);
    assign c_minus   = (bus.rx_data == 8'h2D) && (ACCEPT_SIGN != 0);
    // Low nibble of '0'..'9' is the digit value itself.
    assign digit_val = bus.rx_data[3:0];
    assign acc_x10   = (acc_q << 3) + (acc_q << 1) + {{(AW-4){1'b0}}, digit_val};

    // Next-state and output decode for one consumed character
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        ovf_d   = ovf_q;
        vv_d    = 1'b0;
        err_d   = 1'b0;
        if (bus.clear) begin
            state_d = IDLE;
            acc_d   = '0;
            neg_d   = 1'b0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (bus.rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (c_term) begin
                        state_d = IDLE;
                    end else if (c_minus) begin
                        neg_d   = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = SIGN;
                    end else if (c_digit) begin
                        acc_d   = {{(AW-4){1'b0}}, digit_val};
                        cnt_d   = 4'd1;
                        neg_d   = 1'b0;
                        ovf_d   = 1'b0;
                        state_d = ACCUM;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DISCARD;
                    end
                end
                SIGN: begin
                    if (c_digit) begin
                        acc_d   = {{(AW-4){1'b0}}, digit_val};
                        cnt_d   = 4'd1;
                        state_d = ACCUM;
                    end else if (c_term) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DISCARD;
                    end
                end
                ACCUM: begin
                    if (c_digit) begin
                        if ((cnt_q == MAXD) || (acc_x10 > limit_for(neg_q))) begin
                            ovf_d   = 1'b1;
                            err_d   = 1'b1;
                            state_d = DISCARD;
                        end else begin
                            acc_d = acc_x10;
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (c_term) begin
                        value_d = apply_sign(acc_q[DATA_WIDTH-1:0], neg_q);
                        vv_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DISCARD;
                    end
                end
                DISCARD: begin
                    if (c_term) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            value_q <= '0;
            vv_q    <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            vv_q    <= vv_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.value       = value_q;
    assign bus.value_valid = vv_q;
    assign bus.digit_count = cnt_q;
    assign bus.error       = err_q;
    assign bus.overflow    = ovf_q;
    assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_ascii_number_parser.sv
// Bench for ascii_number_parser: three configurations driven with the same
// character stream, checked every cycle against a token-level model and
// against a table of hand-derived results.
module tb_ascii_number_parser;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ascii_number_parser_if #(.DATA_WIDTH(32)) b0 ();
    ascii_number_parser_if #(.DATA_WIDTH(32)) b1 ();
    ascii_number_parser_if #(.DATA_WIDTH(16)) b2 ();

    ascii_number_parser #(.DATA_WIDTH(32), .MAX_DIGITS(10), .ACCEPT_SIGN(1))
        dut0 (.clk(clk), .reset(reset), .bus(b0));
    ascii_number_parser #(.DATA_WIDTH(32), .MAX_DIGITS(10), .ACCEPT_SIGN(0))
        dut1 (.clk(clk), .reset(reset), .bus(b1));
    ascii_number_parser #(.DATA_WIDTH(16), .MAX_DIGITS(4), .ACCEPT_SIGN(1))
        dut2 (.clk(clk), .reset(reset), .bus(b2));

    int  P_DW   [3] = '{32, 32, 16};
    int  P_MAXD [3] = '{10, 10, 4};
    bit  P_SGN  [3] = '{1'b1, 1'b0, 1'b1};

    // Model state: token text collected so far, plus observable outputs.
    bit          m_disc [3];
    bit          m_tok  [3];
    bit          m_neg  [3];
    string       m_digs [3];
    logic [31:0] m_val  [3];
    int          m_cnt  [3];
    bit          m_ovf  [3];
    bit          m_vv   [3];
    bit          m_err  [3];

    int total = 0;
    int bad   = 0;
    int n_vv  [3];
    int n_err [3];

    function automatic longint unsigned str_num(input string s);
        longint unsigned v = 0;
        for (int i = 0; i < s.len(); i++) v = v * 10 + longint'(s[i]) - 48;
        return v;
    endfunction

    function automatic longint unsigned limit_of(input int k, input bit neg);
        longint unsigned one = 1;
        if (!P_SGN[k]) return (one << P_DW[k]) - 1;
        if (neg) return one << (P_DW[k] - 1);
        return (one << (P_DW[k] - 1)) - 1;
    endfunction

    task automatic model_reset(input int k);
        m_disc[k] = 0; m_tok[k] = 0; m_neg[k] = 0; m_digs[k] = "";
        m_val[k] = '0; m_cnt[k] = 0; m_ovf[k] = 0; m_vv[k] = 0; m_err[k] = 0;
    endtask

    task automatic model_step(input int k, input bit clr, input bit vld, input logic [7:0] c);
        bit dig, term, minus;
        string nd;
        longint unsigned v, mask;
        m_vv[k] = 0; m_err[k] = 0;
        if (clr) begin
            m_disc[k] = 0; m_tok[k] = 0; m_neg[k] = 0; m_digs[k] = "";
            m_cnt[k] = 0; m_ovf[k] = 0;
            return;
        end
        if (!vld) return;
        dig   = (c >= 8'h30) && (c <= 8'h39);
        term  = (c == 8'h0D) || (c == 8'h0A) || (c == 8'h20) || (c == 8'h2C);
        minus = (c == 8'h2D) && P_SGN[k];
        if (m_disc[k]) begin
            if (term) m_disc[k] = 0;
            return;
        end
        if (!m_tok[k]) begin
            if (term) begin
            end else if (minus) begin
                m_tok[k] = 1; m_neg[k] = 1; m_digs[k] = ""; m_cnt[k] = 0;
            end else if (dig) begin
                m_tok[k] = 1; m_neg[k] = 0; m_digs[k] = $sformatf("%c", c);
                m_cnt[k] = 1; m_ovf[k] = 0;
            end else begin
                m_err[k] = 1; m_disc[k] = 1;
            end
            return;
        end
        if (dig) begin
            nd = $sformatf("%s%c", m_digs[k], c);
            if (m_digs[k].len() == P_MAXD[k] || str_num(nd) > limit_of(k, m_neg[k])) begin
                m_ovf[k] = 1; m_err[k] = 1; m_disc[k] = 1; m_tok[k] = 0;
            end else begin
                m_digs[k] = nd; m_cnt[k] = nd.len();
            end
        end else if (term) begin
            m_tok[k] = 0;
            if (m_digs[k].len() == 0) begin
                m_err[k] = 1;
            end else begin
                mask = (longint'(1) << P_DW[k]) - 1;
                v = str_num(m_digs[k]);
                if (m_neg[k]) v = 0 - v;
                m_val[k] = 32'(v & mask);
                m_vv[k] = 1;
            end
        end else begin
            m_err[k] = 1; m_disc[k] = 1; m_tok[k] = 0;
        end
    endtask

    task automatic read_outs(input int k, output logic [31:0] val, output bit vv,
                             output bit err, output bit ovf, output bit busy, output int cnt);
        case (k)
            0: begin val = b0.value; vv = b0.value_valid; err = b0.error;
                     ovf = b0.overflow; busy = b0.busy; cnt = int'(b0.digit_count); end
            1: begin val = b1.value; vv = b1.value_valid; err = b1.error;
                     ovf = b1.overflow; busy = b1.busy; cnt = int'(b1.digit_count); end
            default: begin val = {16'h0, b2.value}; vv = b2.value_valid; err = b2.error;
                     ovf = b2.overflow; busy = b2.busy; cnt = int'(b2.digit_count); end
        endcase
    endtask

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input int k);
        logic [31:0] val; bit vv, err, ovf, busy; int cnt;
        read_outs(k, val, vv, err, ovf, busy, cnt);
        chk($sformatf("u%0d.value_valid", k), vv, m_vv[k]);
        chk($sformatf("u%0d.error", k), err, m_err[k]);
        chk($sformatf("u%0d.value", k), val, m_val[k]);
        chk($sformatf("u%0d.digit_count", k), cnt, m_cnt[k]);
        chk($sformatf("u%0d.overflow", k), ovf, m_ovf[k]);
        chk($sformatf("u%0d.busy", k), busy, m_tok[k] | m_disc[k]);
        n_vv[k]  += int'(vv);
        n_err[k] += int'(err);
    endtask

    task automatic cycle(input bit clr, input bit vld, input logic [7:0] c);
        b0.clear = clr; b0.rx_valid = vld; b0.rx_data = c;
        b1.clear = clr; b1.rx_valid = vld; b1.rx_data = c;
        b2.clear = clr; b2.rx_valid = vld; b2.rx_data = c;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!reset) model_reset(k);
            else        model_step(k, clr, vld, c);
        end
        #1;
        for (int k = 0; k < 3; k++) check_model(k);
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) cycle(1'b0, 1'b1, s[i]);
    endtask

    typedef struct {
        string       s;
        int          k;
        logic [31:0] val;
        int          nvv;
        int          nerr;
        bit          ovf;
        int          cnt;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [31:0] val; bit vv, err, ovf, busy; int cnt;
        logic [7:0] ch;
        int r;
        logic [7:0] terms [4] = '{8'h0D, 8'h0A, 8'h20, 8'h2C};
        logic [7:0] ills  [5] = '{8'h61, 8'h2E, 8'h2B, 8'h00, 8'hFF};

        vecs[0]  = '{"123\015",          0, 32'd123,        1, 0, 1'b0, 3};
        vecs[1]  = '{"-45\n",            0, 32'hFFFFFFD3,   1, 0, 1'b0, 2};
        vecs[2]  = '{"-2147483648 ",     0, 32'h80000000,   1, 0, 1'b0, 10};
        vecs[3]  = '{"2147483648 ",      0, 32'h80000000,   0, 1, 1'b1, 9};
        vecs[4]  = '{"4294967296\015",   1, 32'h80000000,   0, 1, 1'b1, 9};
        vecs[5]  = '{"4294967295\015",   1, 32'hFFFFFFFF,   1, 0, 1'b0, 10};
        vecs[6]  = '{"-5\015",           1, 32'hFFFFFFFF,   0, 1, 1'b0, 0};
        vecs[7]  = '{"12a4\0157\015",    0, 32'd7,          1, 1, 1'b0, 1};
        vecs[8]  = '{"-\015",            0, 32'd7,          0, 1, 1'b0, 0};
        vecs[9]  = '{"1,2,3,",           0, 32'd3,          3, 0, 1'b0, 1};
        vecs[10] = '{"99999\015",        2, 32'd3,          0, 1, 1'b1, 4};
        vecs[11] = '{"-9999\015",        2, 32'h0000D8F1,   1, 0, 1'b0, 4};

        reset = 1'b0;
        b0.clear = 0; b0.rx_valid = 0; b0.rx_data = 0;
        b1.clear = 0; b1.rx_valid = 0; b1.rx_data = 0;
        b2.clear = 0; b2.rx_valid = 0; b2.rx_data = 0;
        for (int k = 0; k < 3; k++) begin model_reset(k); n_vv[k] = 0; n_err[k] = 0; end
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        read_outs(0, val, vv, err, ovf, busy, cnt);
        chk("reset.value", val, 0);
        chk("reset.busy", busy, 0);
        chk("reset.overflow", ovf, 0);
        chk("reset.digit_count", cnt, 0);
        reset = 1'b1;
        cycle(1'b0, 1'b0, 8'h00);

        // Table of whole-token results
        for (int i = 0; i < 12; i++) begin
            int k;
            k = vecs[i].k;
            cycle(1'b1, 1'b0, 8'h00);
            n_vv[k] = 0; n_err[k] = 0;
            send(vecs[i].s);
            cycle(1'b0, 1'b0, 8'h00);
            read_outs(k, val, vv, err, ovf, busy, cnt);
            chk($sformatf("vec%0d.value", i), val, vecs[i].val);
            chk($sformatf("vec%0d.vv_pulses", i), n_vv[k], vecs[i].nvv);
            chk($sformatf("vec%0d.err_pulses", i), n_err[k], vecs[i].nerr);
            chk($sformatf("vec%0d.overflow", i), ovf, vecs[i].ovf);
            chk($sformatf("vec%0d.digit_count", i), cnt, vecs[i].cnt);
        end

        // Reset mid-number: asynchronous effect, then clean restart
        send("98");
        read_outs(0, val, vv, err, ovf, busy, cnt);
        chk("midrst.busy_before", busy, 1);
        reset = 1'b0;
        #1;
        read_outs(0, val, vv, err, ovf, busy, cnt);
        chk("midrst.async_value", val, 0);
        chk("midrst.async_busy", busy, 0);
        chk("midrst.async_count", cnt, 0);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        reset = 1'b1;
        send("5\015");
        read_outs(0, val, vv, err, ovf, busy, cnt);
        chk("midrst.value", val, 5);
        chk("midrst.digit_count", cnt, 1);

        // Clear together with a digit drops both the number and that digit
        send("3");
        cycle(1'b1, 1'b1, 8'h36);
        read_outs(0, val, vv, err, ovf, busy, cnt);
        chk("clear.busy", busy, 0);
        chk("clear.digit_count", cnt, 0);
        send("1\015");
        read_outs(0, val, vv, err, ovf, busy, cnt);
        chk("clear.value", val, 1);

        // Sticky overflow released by the next digit accepted from idle
        send("99999999999\015");
        read_outs(0, val, vv, err, ovf, busy, cnt);
        chk("ovf.set", ovf, 1);
        chk("ovf.value_kept", val, 1);
        send("5");
        read_outs(0, val, vv, err, ovf, busy, cnt);
        chk("ovf.released", ovf, 0);
        send("\015");
        read_outs(0, val, vv, err, ovf, busy, cnt);
        chk("ovf.value", val, 5);

        // Random character stream
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      ch = 8'h30 + 8'($urandom_range(0, 9));
            else if (r < 75) ch = terms[$urandom_range(0, 3)];
            else if (r < 85) ch = 8'h2D;
            else             ch = ills[$urandom_range(0, 4)];
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, ch);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
